// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a 2-entry FIFO per lane.
// Define DEMUX4_BCAST_EN to add the in_bcast port, which pushes one word into all four lanes at once.
module demux4_stream #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
`ifdef DEMUX4_BCAST_EN
    input  logic                 in_bcast,
`endif
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           lane_full
);

    logic [WIDTH-1:0] mem_q   [4][2];
    logic [WIDTH-1:0] mem_d   [4][2];
    logic [1:0]       count_q [4];
    logic [1:0]       count_d [4];
    logic [3:0]       wrPtr_q, wrPtr_d;
    logic [3:0]       rdPtr_q, rdPtr_d;
    logic [3:0]       laneReady;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic             accept;

    // in_ready looks only at registered occupancy and the selector, never at out_ready.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            laneReady[k] = (count_q[k] != 2'd2);
        end
        in_ready = laneReady[in_sel];
`ifdef DEMUX4_BCAST_EN
        if (in_bcast) begin
            in_ready = &laneReady;
        end
`endif
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            push[k] = accept && (in_sel == 2'(k));
`ifdef DEMUX4_BCAST_EN
            if (in_bcast) begin
                push[k] = accept;
            end
`endif
            out_valid[k]                 = (count_q[k] != 2'd0);
            lane_full[k]                 = (count_q[k] == 2'd2);
            pop[k]                       = out_valid[k] && out_ready[k];
            out_data[k*WIDTH +: WIDTH]   = mem_q[k][rdPtr_q[k]];
        end
    end

    // A push and a pop in the same cycle advance both pointers and leave the count unchanged.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        wrPtr_d = wrPtr_q ^ push;
        rdPtr_d = rdPtr_q ^ pop;
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_d[k][wrPtr_q[k]] = in_data;
            end
            case ({push[k], pop[k]})
                2'b10:   count_d[k] = count_q[k] + 2'd1;
                2'b01:   count_d[k] = count_q[k] - 2'd1;
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= 4'b0000;
            rdPtr_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                count_q[k]  <= 2'd0;
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            for (int k = 0; k < 4; k++) begin
                count_q[k]  <= count_d[k];
                mem_q[k][0] <= mem_d[k][0];
                mem_q[k][1] <= mem_d[k][1];
            end
        end
    end

endmodule
